// File: rtl/bus6502_pkg.sv
// Shared types and constants for the 6502 test-system bus master.
package bus6502_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [15:0] PERIPH_LO   = 16'hD010;
  localparam logic [15:0] PERIPH_HI   = 16'hD0FF;
  localparam logic [15:0] REG_KBDCR   = 16'hD011;
  localparam logic [15:0] REG_DSP     = 16'hD012;
  localparam logic [15:0] REG_KBD_ALT = 16'hD0F2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_HOLD
  } state_e;

  function automatic logic in_periph(input logic [15:0] addr);
    return (addr >= PERIPH_LO) && (addr <= PERIPH_HI);
  endfunction

endpackage

// File: rtl/bus6502_phase_timer.sv
// Loadable down-counter; terminal count flags the last cycle of a bus phase.
module bus6502_phase_timer
  import bus6502_pkg::*;
(
  input  logic             eclk,
  input  logic             ereset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_c_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/bus6502_master.sv
// phi2-timed bus initiator for the 6502 test-system RAM/peripheral responder.
// Optional write readback verification: define BUS6502_MASTER_VERIFY_EN.
module bus6502_master
  import bus6502_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned SETUP_LEN = 1
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        clk,
  output logic [15:0] a,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        rw,
  output logic        verify_err,
  output logic [15:0] err_addr
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_LEN - 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_LEN - 1);

  state_e      state_q;
  logic        clk_q;
  logic        rw_q;
  logic [15:0] a_q;
  logic [7:0]  dout_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;

  logic             tc_c;
  logic             load_c;
  logic [CNT_W-1:0] load_val_c;
  logic             readback_next_c;

`ifdef BUS6502_MASTER_VERIFY_EN
  logic        readback_q;
  logic        verify_err_q;
  logic [15:0] err_addr_q;
`endif

  bus6502_phase_timer u_timer (
    .eclk       (eclk),
    .ereset     (ereset),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .tc_c_o     (tc_c)
  );

  // A completed non-peripheral write chains straight into a readback.
  always_comb begin
    readback_next_c = 1'b0;
`ifdef BUS6502_MASTER_VERIFY_EN
    readback_next_c = !rw_q && !in_periph(a_q);
`endif
  end

  // Timer is reloaded on entry to every timed state.
  always_comb begin
    load_c     = 1'b0;
    load_val_c = SETUP_LOAD;
    unique case (state_q)
      ST_IDLE:  load_c = cmd_valid;
      ST_SETUP: begin
        load_c     = tc_c;
        load_val_c = PHASE_LOAD;
      end
      ST_HIGH: begin
        load_c     = tc_c;
        load_val_c = PHASE_LOAD;
      end
      ST_HOLD:  load_c = tc_c && readback_next_c;
      default:  load_c = 1'b0;
    endcase
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state_q     <= ST_IDLE;
      clk_q       <= 1'b0;
      rw_q        <= 1'b1;
      a_q         <= '0;
      dout_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef BUS6502_MASTER_VERIFY_EN
      readback_q   <= 1'b0;
      verify_err_q <= 1'b0;
      err_addr_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_q         <= cmd_addr;
            dout_q      <= cmd_data;
            rw_q        <= !cmd_write;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_SETUP;
`ifdef BUS6502_MASTER_VERIFY_EN
            readback_q  <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (tc_c) begin
            clk_q   <= 1'b1;
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tc_c) begin
            clk_q   <= 1'b0;
            state_q <= ST_HOLD;
            if (rw_q) begin
`ifdef BUS6502_MASTER_VERIFY_EN
              if (readback_q) begin
                if (din != dout_q) begin
                  verify_err_q <= 1'b1;
                  if (!verify_err_q) err_addr_q <= a_q;
                end
              end else begin
                rsp_data_q  <= din;
                rsp_valid_q <= 1'b1;
              end
`else
              rsp_data_q  <= din;
              rsp_valid_q <= 1'b1;
`endif
            end
          end
        end
        ST_HOLD: begin
          if (tc_c) begin
            rw_q <= 1'b1;
            if (readback_next_c) begin
              state_q <= ST_SETUP;
`ifdef BUS6502_MASTER_VERIFY_EN
              readback_q <= 1'b1;
`endif
            end else begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clk       = clk_q;
  assign rw        = rw_q;
  assign a         = a_q;
  assign dout      = dout_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef BUS6502_MASTER_VERIFY_EN
  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;
`else
  assign verify_err = 1'b0;
  assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_bus6502_master.sv
// Directed bench for bus6502_master with a RAM/display responder stub.
module tb_bus6502_master;
  import bus6502_pkg::*;

`ifdef BUS6502_MASTER_VERIFY_EN
  localparam int TXN_W = 19;
`else
  localparam int TXN_W = 10;
`endif

  logic        eclk = 1'b0;
  logic        ereset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        clk, rw;
  logic [15:0] a;
  logic [7:0]  dout, din;
  logic        verify_err;
  logic [15:0] err_addr;

  int checks = 0;
  int errors = 0;

  bus6502_master dut (
    .eclk(eclk), .ereset(ereset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clk(clk), .a(a), .dout(dout), .din(din), .rw(rw),
    .verify_err(verify_err), .err_addr(err_addr)
  );

  always #5 eclk = ~eclk;

  // Responder: registers phi2 once, commits writes on the detected falling edge.
  logic [7:0] mem [0:65535];
  logic       clk_r;
  logic       disp_seen;
  logic [6:0] disp_reg;
  logic       display_ready;
  assign display_ready = 1'b0;

  always @(posedge eclk) begin
    clk_r <= clk;
    if (ereset) disp_seen <= 1'b0;
    if (clk_r && !clk && !rw) begin
      if (a == REG_DSP) begin
        if (!disp_seen) disp_seen <= 1'b1;
        else disp_reg <= dout[6:0];
      end else begin
        mem[a] <= dout;
      end
    end
  end

  // Bit0 at 0x0500 reads back corrupted.
  always_comb begin
    if (a == REG_DSP)        din = {!display_ready, disp_reg};
    else if (a == 16'h0500)  din = mem[a] ^ 8'h01;
    else                     din = mem[a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] addr, input logic [7:0] data);
    cmd_write = w;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 16'hFFFF;
    cmd_data  = 8'hEE;
  endtask

  // Waits for cmd_ready; reports response pulses and total cycles since issue.
  task automatic wait_idle(output int pulses, output logic [7:0] data, output int cycles);
    int n = 0;
    pulses = 0;
    data   = 8'h00;
    while (!cmd_ready && n < 200) begin
      if (rsp_valid) begin
        pulses++;
        data = rsp_data;
      end
      tick();
      n++;
    end
    cycles = n + 1;
    if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         pulses, cyc, n;
    int         acc [3];
    logic [7:0] data;
    logic [7:0] bb_data [3];

    bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33;
    ereset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0000;
    cmd_data  = 8'h00;
    repeat (3) @(posedge eclk);
    #1;

    // Reset state
    chk("rst_clk", 32'(clk), 32'd0);
    chk("rst_rw", 32'(rw), 32'd1);
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_verify_err", 32'(verify_err), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'h0);
    ereset = 1'b0;
    tick();

    // Write timing: 0xA5 -> 0x0200
    cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_data = 8'hA5; cmd_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_addr = 16'hFFFF; cmd_data = 8'hEE;
      end
      chk($sformatf("wr_clk_c%0d", k), 32'(clk), 32'((k >= 2 && k <= 5) ? 1 : 0));
      if (k <= 9) begin
        chk($sformatf("wr_a_c%0d", k), 32'(a), 32'h0200);
        chk($sformatf("wr_rw_c%0d", k), 32'(rw), 32'd0);
        chk($sformatf("wr_dout_c%0d", k), 32'(dout), 32'hA5);
        chk($sformatf("wr_ready_c%0d", k), 32'(cmd_ready), 32'd0);
      end
`ifndef BUS6502_MASTER_VERIFY_EN
      if (k == 10) chk("wr_ready_c10", 32'(cmd_ready), 32'd1);
`endif
    end
    wait_idle(pulses, data, cyc);
    chk("wr_mem_0200", 32'(mem[16'h0200]), 32'hA5);

    // Read back 0x0200
    cmd_write = 1'b0; cmd_addr = 16'h0200; cmd_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_addr = 16'hFFFF;
      end
      chk($sformatf("rd_valid_c%0d", k), 32'(rsp_valid), 32'((k == 6) ? 1 : 0));
      chk($sformatf("rd_rw_c%0d", k), 32'(rw), 32'd1);
      if (k == 6) chk("rd_data", 32'(rsp_data), 32'hA5);
    end
    chk("rd_ready_c10", 32'(cmd_ready), 32'd1);

    // Back-to-back writes with cmd_valid held
    n = 0; cyc = 0;
    cmd_write = 1'b1; cmd_addr = 16'h0300; cmd_data = bb_data[0]; cmd_valid = 1'b1;
    while (n < 3 && cyc < 200) begin
      if (cmd_ready) begin
        acc[n] = cyc;
        n++;
        tick(); cyc++;
        if (n < 3) begin
          cmd_addr = 16'h0300 + 16'(n);
          cmd_data = bb_data[n];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        tick(); cyc++;
      end
    end
    chk("b2b_accepted", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < n) chk($sformatf("b2b_acc%0d", i), 32'(acc[i]), 32'(i * TXN_W));
    wait_idle(pulses, data, cyc);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_mem%0d", i), 32'(mem[16'h0300 + 16'(i)]), 32'(bb_data[i]));

    // Reset during HIGH of a write
    issue(1'b1, 16'h0400, 8'h33);
    wait_idle(pulses, data, cyc);
    cmd_write = 1'b1; cmd_addr = 16'h0400; cmd_data = 8'h5A; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("rstw_clk_high", 32'(clk), 32'd1);
    chk("rstw_rw_low", 32'(rw), 32'd0);
    ereset = 1'b1;
    #1;
    chk("rstw_clk", 32'(clk), 32'd0);
    chk("rstw_rw", 32'(rw), 32'd1);
    tick(); tick();
    ereset = 1'b0;
    tick();
    chk("rstw_ready", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    chk("rstw_mem", 32'(mem[16'h0400]), 32'h33);

    // Peripheral display register
    issue(1'b1, REG_DSP, 8'h11);
    wait_idle(pulses, data, cyc);
    issue(1'b1, REG_DSP, 8'h41);
    wait_idle(pulses, data, cyc);
    issue(1'b0, REG_DSP, 8'h00);
    wait_idle(pulses, data, cyc);
    chk("per_pulses", 32'(pulses), 32'd1);
    chk("per_data", 32'(data), 32'hC1);

    // Readback verification (corrupting address, then peripheral write)
    issue(1'b1, 16'h0500, 8'h10);
    wait_idle(pulses, data, cyc);
    chk("ver_cycles", 32'(cyc), 32'(TXN_W));
    chk("ver_pulses", 32'(pulses), 32'd0);
`ifdef BUS6502_MASTER_VERIFY_EN
    chk("ver_err", 32'(verify_err), 32'd1);
    chk("ver_addr", 32'(err_addr), 32'h0500);
`else
    chk("ver_err", 32'(verify_err), 32'd0);
    chk("ver_addr", 32'(err_addr), 32'h0);
`endif
    issue(1'b1, REG_DSP, 8'h22);
    wait_idle(pulses, data, cyc);
    chk("ver_per_cycles", 32'(cyc), 32'd10);
`ifdef BUS6502_MASTER_VERIFY_EN
    chk("ver_per_err", 32'(verify_err), 32'd1);
    chk("ver_per_addr", 32'(err_addr), 32'h0500);
`else
    chk("ver_per_err", 32'(verify_err), 32'd0);
    chk("ver_per_addr", 32'(err_addr), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
